// File: rtl/hsi2rgb_pipe.sv
// rtl/hsi2rgb_pipe.sv - three-stage HSI to RGB converter with valid/ready flow control
// Hue in degrees, saturation/intensity unsigned; out-of-range channels saturate and are counted.
module hsi2rgb_pipe #(
    parameter int DW = 8,
    parameter int HW = 9,
    parameter int UW = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid,
    output logic          oReady,
    input  logic [HW-1:0] iH,
    input  logic [DW-1:0] iS,
    input  logic [DW-1:0] iI,
    input  logic [UW-1:0] iUser,
    output logic          oValid,
    input  logic          iReady,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic [UW-1:0] oUser,
    output logic [15:0]   oClipCnt
);
    localparam int PW = 2*DW + HW;
    localparam int SW = PW + 2;
    localparam logic [PW-1:0]        MAXP = PW'(2**DW - 1);
    localparam logic signed [SW-1:0] MAXS = SW'(2**DW - 1);

    logic en;
    assign en     = !oValid || iReady;
    assign oReady = en;

    // stage 1: hue wrap (single subtraction) and I*S product
    logic [HW:0]   h_ext;
    logic [HW-1:0] h_norm;
    logic [2*DW-1:0] is_n;
    assign h_ext  = {1'b0, iH};
    assign h_norm = (h_ext >= (HW+1)'(360)) ? HW'(h_ext - (HW+1)'(360)) : iH;
    assign is_n   = {{DW{1'b0}}, iI} * {{DW{1'b0}}, iS};

    logic            v1;
    logic [HW-1:0]   h1;
    logic [2*DW-1:0] is1;
    logic [DW-1:0]   i1;
    logic [UW-1:0]   u1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= iValid;
            if (iValid) begin
                h1  <= h_norm;
                is1 <= is_n;
                i1  <= iI;
                u1  <= iUser;
            end
        end
    end

    // stage 2: scaled terms, minimum component and sector
    logic [PW-1:0] is_p, prod, is2_n, hs_n;
    logic [DW-1:0] mn_n;
    logic [1:0]    sec_n;
    assign is_p  = PW'(is1);
    assign prod  = is_p * PW'(h1);
    assign is2_n = (is_p * PW'(3)) / MAXP;
    assign hs_n  = prod / (MAXP * PW'(40));
    assign mn_n  = i1 - DW'(is_p / MAXP);
    assign sec_n = (h1 < HW'(120)) ? 2'd0 : (h1 < HW'(240)) ? 2'd1 : 2'd2;

    logic          v2;
    logic [PW-1:0] is2, hs;
    logic [DW-1:0] mn;
    logic [1:0]    sec;
    logic [UW-1:0] u2;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                is2 <= is2_n;
                hs  <= hs_n;
                mn  <= mn_n;
                sec <= sec_n;
                u2  <= u1;
            end
        end
    end

    // stage 3: signed channel arithmetic, then clamp
    logic signed [SW-1:0] smn, sis2, shs, r_s, g_s, b_s;
    assign smn  = $signed({{(SW-DW){1'b0}}, mn});
    assign sis2 = $signed({2'b00, is2});
    assign shs  = $signed({2'b00, hs});

    always_comb begin
        r_s = smn;
        g_s = smn;
        b_s = smn;
        case (sec)
            2'd0: begin
                r_s = smn + sis2 - shs;
                g_s = smn + shs;
            end
            2'd1: begin
                g_s = smn + sis2 + sis2 - shs;
                b_s = smn + shs - sis2;
            end
            default: begin
                r_s = smn + shs - sis2 - sis2;
                b_s = smn + sis2 + sis2 + sis2 - shs;
            end
        endcase
    end

    function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] x);
        if (x < 0)
            return '0;
        else if (x > MAXS)
            return '1;
        else
            return x[DW-1:0];
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] x);
        return (x < 0) || (x > MAXS);
    endfunction

    logic clip_n, clip_q;
    assign clip_n = out_of_range(r_s) || out_of_range(g_s) || out_of_range(b_s);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oValid   <= 1'b0;
            oRed     <= '0;
            oGreen   <= '0;
            oBlue    <= '0;
            oUser    <= '0;
            clip_q   <= 1'b0;
            oClipCnt <= '0;
        end else begin
            // count on the transfer of the pixel currently presented
            if (oValid && iReady && clip_q && (oClipCnt != 16'hFFFF))
                oClipCnt <= oClipCnt + 16'd1;
            if (en) begin
                oValid <= v2;
                if (v2) begin
                    oRed   <= clamp(r_s);
                    oGreen <= clamp(g_s);
                    oBlue  <= clamp(b_s);
                    oUser  <= u2;
                    clip_q <= clip_n;
                end
            end
        end
    end
endmodule

// File: doc/hsi2rgb_pipe.md
HSI2RGB_PIPE -- requirements
Module: hsi2rgb_pipe

Interface
REQ-001 SHALL have parameter DW, default 8: width of the S, I, R, G and B channels. Define MAX = 2^DW-1.
REQ-002 SHALL have parameter HW, default 9: hue width; hue unit is degrees.
REQ-003 SHALL have parameter UW, default 2: width of the sideband (SOF/EOL etc.) carried alongside each pixel.
REQ-004 SHALL have port iCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port iValid, input, 1 bit: upstream pixel valid.
REQ-007 SHALL have port oReady, output, 1 bit: block can accept a pixel this cycle.
REQ-008 SHALL have ports iH (input, HW bits), iS (input, DW bits) and iI (input, DW bits): hue, saturation and intensity.
REQ-009 SHALL have port iUser, input, UW bits: sideband, passed through unmodified.
REQ-010 SHALL have port oValid, output, 1 bit: output pixel valid.
REQ-011 SHALL have port iReady, input, 1 bit: downstream ready.
REQ-012 SHALL have ports oRed, oGreen and oBlue, output, DW bits each: converted pixel.
REQ-013 SHALL have port oUser, output, UW bits: sideband aligned with the pixel.
REQ-014 SHALL have port oClipCnt, output, 16 bits: count of clamped output pixels.

Function
REQ-015 SHALL transfer an input pixel only when iValid && oReady, and an output pixel only when oValid && iReady.
REQ-016 SHALL use a 3-stage pipeline with a global advance enable en = !oValid || iReady; oReady SHALL equal en.
REQ-017 SHALL give a latency of exactly 3 iCLK cycles from input transfer to oValid when unstalled, sustaining 1 pixel/cycle.
REQ-018 SHALL carry a valid bit in each stage; when en=0, all stages, oUser and the outputs SHALL hold.
REQ-019 SHALL keep outputs stable from oValid=1 until the transfer completes.
REQ-020 Stage 1 SHALL normalise hue: H' = iH-360 if iH>=360, else iH. Only one subtraction is applied, so 360..511 maps to 0..151 for HW=9.
REQ-021 Stage 1 SHALL compute IS = iI*iS, 2*DW bits, unsigned.
REQ-022 Stage 2 SHALL compute:
- IS2 = floor(3*IS/MAX)
- HS = floor(IS*H'/(40*MAX)), using a product width of 2*DW+HW
- MN = iI - floor(IS/MAX)
- sector select: 0 if H'<120, 1 if 120<=H'<240, 2 otherwise.
REQ-023 Stage 3 SHALL compute, in signed arithmetic of at least DW+3 bits:
- sector 0: R=MN+IS2-HS, G=MN+HS, B=MN
- sector 1: R=MN, G=MN+2*IS2-HS, B=MN+HS-IS2
- sector 2: R=MN+HS-2*IS2, G=MN, B=MN+3*IS2-HS
REQ-024 SHALL clamp each channel to 0 if negative and to MAX if above MAX; no modular wrap is permitted.
REQ-025 SHALL increment oClipCnt by 1 on each output transfer where any channel was clamped, saturating at 16'hFFFF.
REQ-026 SHALL pass iUser through with the same latency and stall behaviour as the pixel.
REQ-027 iValid while oReady=0 SHALL NOT be captured; upstream holds.

Reset
REQ-028 When iRST=1 at a clock edge, all stage valid bits, oValid, oRed, oGreen, oBlue, oUser and oClipCnt SHALL be 0, and any in-flight pixels SHALL be discarded.
REQ-029 During reset, oReady SHALL be 1 (since oValid=0), but pixels presented while iRST=1 SHALL be dropped.
REQ-030 The first pixel accepted after reset deasserts SHALL appear after 3 cycles.

Verification
REQ-031 Scenario: H=0, S=0, I=128 (DW=8) SHALL produce RGB=(128,128,128) exactly 3 cycles later, with oClipCnt unchanged.
REQ-032 Scenario: S=255, I=85 with H=0, H=120 and H=240 streamed back-to-back SHALL produce (255,0,0), (0,255,0) and (0,0,255) on consecutive cycles.
REQ-033 Scenario: H=400, S=255, I=85 SHALL produce the same RGB as H=40; H=300, S=255, I=85 SHALL produce the same RGB as a reference model of REQ-023/024.
REQ-034 Scenario: stream 8 pixels with iReady toggled randomly SHALL give no loss, no duplication, order preserved, oUser aligned, and outputs held while stalled.
REQ-035 Scenario: assert iRST for 1 cycle with 3 pixels in flight SHALL give oValid=0 and oClipCnt=0 on the next cycle, and those pixels SHALL never emerge.
REQ-036 Scenario: stream a pixel that drives a channel above MAX (e.g. H=60, S=255, I=255) SHALL clamp that channel to 255 and increment oClipCnt by 1; 70000 such transfers SHALL leave oClipCnt at 65535.
